// File: rtl/reset_source_if.sv
// Handshake/status bundle between the reset request generator and its environment.
interface reset_source_if;
  logic       iButton;
  logic       iWdtEnable;
  logic       iWdtKick;
  logic       iSwReset;
  logic       oResetReq;
  logic [2:0] oCause;
  logic       oBusy;

  modport master (
    output iButton,
    output iWdtEnable,
    output iWdtKick,
    output iSwReset,
    input  oResetReq,
    input  oCause,
    input  oBusy
  );

  modport slave (
    input  iButton,
    input  iWdtEnable,
    input  iWdtKick,
    input  iSwReset,
    output oResetReq,
    output oCause,
    output oBusy
  );
endinterface

// File: rtl/reset_source.sv
// Reset request producer: debounced button, watchdog and software strobe
// merged into one fixed-length request pulse with a sticky cause record.
module reset_source #(
  parameter int unsigned DEBOUNCE_BITS  = 16,
  parameter int unsigned WDT_BITS       = 24,
  parameter int unsigned PULSE_LEN      = 4,
  parameter int unsigned BTN_ACTIVE_LOW = 1
) (
  input  logic          iClk,
  input  logic          iReset,
  reset_source_if.slave bus
);

  localparam int unsigned PCNT_W   = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic        BTN_IDLE = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
  logic                     req_q, req_d;
  logic [2:0]               cause_q, cause_d;
  logic                     busy_q, busy_d;

  logic                     s1_q, s2_q;
  logic                     db_q, db_prev_q;
  logic [DEBOUNCE_BITS-1:0] dcnt_q;
  logic [WDT_BITS-1:0]      wcnt_q;
  logic                     sw_prev_q;

  logic                     pressed;
  logic                     btn_evt;
  logic                     wdt_evt;
  logic                     sw_evt;
  logic [2:0]               evt_vec;

  assign pressed = s2_q ^ BTN_IDLE;
  assign btn_evt = db_q & ~db_prev_q;
  assign wdt_evt = bus.iWdtEnable && (state_q == IDLE) && !bus.iWdtKick && (wcnt_q == '1);
  assign sw_evt  = bus.iSwReset & ~sw_prev_q;
  assign evt_vec = {sw_evt, wdt_evt, btn_evt};

  // Button synchronizer and debouncer; any bounce back to db restarts the count.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      s1_q      <= BTN_IDLE;
      s2_q      <= BTN_IDLE;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      s1_q      <= bus.iButton;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      if (pressed == db_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q != '1) begin
        dcnt_q <= dcnt_q + DEBOUNCE_BITS'(1);
      end else begin
        db_q   <= pressed;
        dcnt_q <= '0;
      end
    end
  end

  // Watchdog counter; only runs while enabled and idle, a kick beats expiry.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      wcnt_q <= '0;
    end else if (!bus.iWdtEnable || (state_q != IDLE)) begin
      wcnt_q <= '0;
    end else if (bus.iWdtKick || (wcnt_q == '1)) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_q + WDT_BITS'(1);
    end
  end

  // Software request rising-edge detector.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      sw_prev_q <= 1'b0;
    end else begin
      sw_prev_q <= bus.iSwReset;
    end
  end

  // Request FSM state and output registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      req_q   <= 1'b0;
      cause_q <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: events are only accepted in IDLE, dropped otherwise.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    req_d   = req_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (|evt_vec) begin
          state_d = PULSE;
          pcnt_d  = PCNT_W'(PULSE_LEN - 1);
          cause_d = evt_vec;
          req_d   = 1'b1;
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          req_d   = 1'b0;
          state_d = HOLDOFF;
        end else begin
          pcnt_d = pcnt_q - PCNT_W'(1);
        end
      end
      HOLDOFF: begin
        req_d = 1'b0;
        if (!db_q && !bus.iSwReset) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.oResetReq = req_q;
  assign bus.oCause    = cause_q;
  assign bus.oBusy     = busy_q;

endmodule

// File: tb/tb_reset_source.sv
// Directed bench for reset_source with a pulse scoreboard.
module tb_reset_source;

  typedef struct packed {
    logic [2:0] cause;
    logic [7:0] len;
  } exp_t;

  logic iClk = 1'b0;
  logic iReset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  reset_source_if bus ();

  reset_source #(
    .DEBOUNCE_BITS (3),
    .WDT_BITS      (4),
    .PULSE_LEN     (4),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] cause, input int len);
    exp_t e;
    e.cause = cause;
    e.len   = 8'(len);
    sb_q.push_back(e);
  endtask

  function automatic int quiet_bad();
    return (bus.oResetReq !== 1'b0 || bus.oBusy !== 1'b0 || bus.oCause !== 3'b000) ? 1 : 0;
  endfunction

  // Monitor: measure every request pulse and compare with the scoreboard.
  initial begin
    logic [2:0] cause;
    int         len;
    exp_t       e;
    forever begin
      @(negedge iClk);
      if (bus.oResetReq === 1'b1) begin
        cause = bus.oCause;
        len   = 1;
        while (len < 64) begin
          @(negedge iClk);
          if (bus.oResetReq !== 1'b1) break;
          len++;
        end
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: cause %b len %0d, none expected", cause, len);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_cause", int'(cause), int'(e.cause));
          chk("pulse_len", len, int'(e.len));
        end
      end
    end
  end

  initial begin
    int bad;
    iReset         = 1'b1;
    bus.iButton    = 1'b1;
    bus.iWdtEnable = 1'b0;
    bus.iWdtKick   = 1'b0;
    bus.iSwReset   = 1'b0;
    tick(3);
    chk("rst_req", int'(bus.oResetReq), 0);
    chk("rst_cause", int'(bus.oCause), 0);
    chk("rst_busy", int'(bus.oBusy), 0);
    iReset = 1'b0;

    // 1: idle quiet
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      bad += quiet_bad();
    end
    chk("idle_quiet", bad, 0);

    // 2: button press, debounce, pulse, holdoff until release settles
    bus.iButton = 1'b0;
    push(3'b001, 4);
    tick(10);
    chk("btn_req_early", int'(bus.oResetReq), 0);
    tick(1);
    chk("btn_req_rise", int'(bus.oResetReq), 1);
    chk("btn_cause", int'(bus.oCause), 1);
    chk("btn_busy", int'(bus.oBusy), 1);
    tick(4);
    chk("btn_req_end", int'(bus.oResetReq), 0);
    chk("btn_holdoff", int'(bus.oBusy), 1);
    bus.iButton = 1'b1;
    tick(10);
    chk("btn_holdoff_late", int'(bus.oBusy), 1);
    tick(1);
    chk("btn_idle", int'(bus.oBusy), 0);
    chk("btn_cause_sticky", int'(bus.oCause), 1);

    // 3: bouncing button never accepted
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      bus.iButton = ~bus.iButton;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        bad += (bus.oResetReq !== 1'b0 || bus.oBusy !== 1'b0) ? 1 : 0;
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      bad += (bus.oResetReq !== 1'b0 || bus.oBusy !== 1'b0) ? 1 : 0;
    end
    chk("bounce_quiet", bad, 0);

    // 4: watchdog expiry, then kick at terminal count
    bus.iWdtEnable = 1'b1;
    push(3'b010, 4);
    tick(15);
    chk("wdt_req_early", int'(bus.oResetReq), 0);
    tick(1);
    chk("wdt_req_rise", int'(bus.oResetReq), 1);
    chk("wdt_cause", int'(bus.oCause), 2);
    tick(5);
    chk("wdt_idle", int'(bus.oBusy), 0);
    tick(15);
    bus.iWdtKick = 1'b1;
    tick(1);
    bus.iWdtKick = 1'b0;
    chk("wdt_kick_wins", int'(bus.oResetReq), 0);
    push(3'b010, 4);
    tick(15);
    chk("wdt_restart_early", int'(bus.oResetReq), 0);
    tick(1);
    chk("wdt_restart_fire", int'(bus.oResetReq), 1);
    tick(5);
    bus.iWdtEnable = 1'b0;
    chk("wdt_idle2", int'(bus.oBusy), 0);

    // 5: software edge coincident with watchdog expiry, sw held through holdoff
    tick(1);
    bus.iWdtEnable = 1'b1;
    push(3'b110, 4);
    tick(15);
    bus.iSwReset = 1'b1;
    tick(1);
    chk("both_req_rise", int'(bus.oResetReq), 1);
    chk("both_cause", int'(bus.oCause), 6);
    tick(4);
    chk("both_req_end", int'(bus.oResetReq), 0);
    chk("sw_holdoff", int'(bus.oBusy), 1);
    tick(10);
    chk("sw_holdoff_late", int'(bus.oBusy), 1);
    bus.iSwReset   = 1'b0;
    bus.iWdtEnable = 1'b0;
    tick(1);
    chk("sw_release_idle", int'(bus.oBusy), 0);

    // 6: reset during the second pulse cycle truncates the pulse
    tick(3);
    bus.iSwReset = 1'b1;
    push(3'b100, 2);
    tick(1);
    chk("sw_req_rise", int'(bus.oResetReq), 1);
    chk("sw_cause", int'(bus.oCause), 4);
    tick(1);
    iReset       = 1'b1;
    bus.iSwReset = 1'b0;
    tick(1);
    chk("midrst_req", int'(bus.oResetReq), 0);
    chk("midrst_cause", int'(bus.oCause), 0);
    chk("midrst_busy", int'(bus.oBusy), 0);
    iReset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      bad += quiet_bad();
    end
    chk("post_rst_quiet", bad, 0);

    tick(4);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
